eth_tx_pkt_loader: RTL
======================

Name: eth_tx_pkt_loader

Overview:
Upstream feeder for ethernet_controller's TX path. Accepts one packet at a time on a 64-bit AXI-stream-style input. Drives the controller's MMIO register port in the same sequence host software uses:
- poll TX-ready (0x101C)
- fill the TX buffer (0x0800+)
- write the size (0x1028)
- kick send (0x1018)

This frees the host from byte-level MMIO and gives a hardware packet source for loopback benches.

Parameters:
- buf_size_p, 2048, TX buffer size in bytes; the maximum packet length.
- axis_width_p, 64, stream and MMIO data width in bits; only 64 is supported.
- reg_addr_width_p, 16, MMIO address width.
- poll_limit_p, 100000, maximum TX-ready poll attempts per packet before abort.

Ports:
- clk_i  in  1  clock; same domain as the controller's clk_i.
- reset_n_i  in  1  asynchronous active-low reset.
- s_data_i  in  64  stream data; byte 0 is in [7:0].
- s_keep_i  in  8  byte enables. Must be 8'hFF on non-last beats. On the last beat, must be contiguous from bit 0 and nonzero.
- s_last_i  in  1  final beat of packet.
- s_valid_i  in  1  beat valid.
- s_ready_o  out  1  beat accepted when s_valid_i & s_ready_o.
- addr_o  out  reg_addr_width_p  MMIO address to the controller.
- write_en_o  out  1  MMIO write strobe.
- read_en_o  out  1  MMIO read strobe.
- op_size_o  out  2  0=1B, 1=2B, 2=4B, 3=8B.
- write_data_o  out  64  MMIO write data, LSB-aligned.
- read_data_i  in  64  controller read data.
- read_data_v_i  in  1  read data valid; arrives the cycle after read_en_o.
- busy_o  out  1  FSM not in IDLE.
- sent_o  out  1  one-cycle pulse when the send write (0x1018) issues.
- err_o  out  1  one-cycle pulse on abort.
- err_code_o  out  2  1=poll timeout, 2=oversize, 3=bad keep. Held until the next err_o.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - FSM=IDLE; every output=0; byte counter=0; poll counter=0.
- At most one of write_en_o / read_en_o is high per cycle. op_size_o and addr_o are don't-care when both are low.
- IDLE:
  - s_valid_i=1 -> POLL_REQ.
  - s_ready_o=0; the beat is not consumed.
- POLL_REQ:
  - read_en_o=1, addr=0x101C, op_size=2. Next state POLL_WAIT.
- POLL_WAIT:
  - No strobe.
  - read_data_v_i=1 and read_data_i[31:0]==1 -> STREAM.
  - Otherwise increment the poll counter:
    - counter == poll_limit_p -> DRAIN with err_code=1.
    - else -> POLL_REQ.
  - read_data_v_i=0 -> stay in POLL_WAIT. Protocol violation; assertion in sim.
- STREAM, full beat (keep=FF):
  - write_en_o=1, addr=0x0800+byte_cnt, op_size=3, data=s_data_i.
  - s_ready_o=1 in the same cycle; byte_cnt+=8.
  - One beat per cycle.
- STREAM, tail beat (last, keep<FF):
  - n = popcount(keep), 1..7.
  - Issue up to three writes on consecutive cycles in the order 4B, 2B, 1B, skipping absent pieces.
  - Each write targets 0x0800+byte_cnt+offset, with data shifted LSB-aligned.
  - s_ready_o=1 only on the cycle of the final piece.
- Last beat accepted -> SIZE: write 0x1028, op_size=2, data=total bytes (zero-extended).
- SEND:
  - write 0x1018, op_size=2, data=0; sent_o=1.
  - Next state IDLE; byte_cnt cleared.
- Oversize:
  - A beat that would make byte_cnt exceed buf_size_p issues no write -> DRAIN with err_code=2.
  - Exactly buf_size_p bytes is legal.
- Bad keep (non-FF keep on a non-last beat, non-contiguous keep, or keep=0) -> DRAIN with err_code=3; no write for that beat.
- DRAIN:
  - s_ready_o=1 and discard beats through s_last_i (the beat triggering the abort counts if it is last).
  - err_o pulses on entry; no MMIO activity; no size/send writes.
  - Then IDLE.
- Latency:
  - 60-byte packet, controller ready on the first poll: 12 cycles from s_valid_i to sent_o.
  - Breakdown: poll 2, 7 full writes, 1 tail write, size, send.
- Reset mid-packet:
  - Everything returns to IDLE.
  - The controller buffer is left partially written; it is harmless because size/send were not issued.

Optional Feature:
ETH_TX_LOADER_STATS_EN:
- Defined: adds outputs pkt_cnt_o (32) and byte_cnt_o (32), plus input stats_clr_i.
  - Counters increment on each sent_o by 1 and by the packet length respectively, and wrap at 2^32.
  - stats_clr_i zeroes both counters; a coincident sent_o is then counted after the clear, giving 1 and len.
  - Both counters reset to 0.
- Undefined: these ports and counters are absent.

Decomposition:
- Package eth_ctrl_pkg: register address constants (TX_BUF_BASE=0x0800, TX_READY=0x101C, TX_SEND=0x1018, TX_SIZE=0x1028), the op_size enum, the FSM state enum, and the err_code enum.
- Sub-module eth_tx_tail_splitter (combinational):
  - Inputs: remaining tail byte count and beat data.
  - Outputs: current piece op_size, byte offset, shifted data, and a last_piece flag.

Test Plan:
- 60-byte packet, ready=1 on the first poll -> writes at 0x0800..0x0830 (8B), 0x0838 (4B), then 0x1028 data=60 and 0x1018; sent_o at cycle 12.
- 63-byte packet (tail keep=8'h7F) -> tail writes 0x0838/4B, 0x083C/2B, 0x083E/1B with correct LSB-aligned bytes; size=63.
- TX-ready read returns 0 for 5 polls, then 1 -> exactly 6 reads of 0x101C before the first buffer write.
- poll_limit_p=3, ready stuck at 0 -> err_o with err_code=1 after 4 reads; stream drained; no write to 0x1018.
- 2056-byte packet -> no write at or above 0x1000 from the buffer path; err_code=2; remaining beats drained; the next 100-byte packet sends correctly.
- Non-last beat with keep=8'h0F -> err_code=3; drain to s_last_i. With STATS_EN defined, pkt_cnt_o is unchanged.

Source files
------------

// File: rtl/eth_ctrl_pkg.sv
// rtl/eth_ctrl_pkg.sv - register map, enums and keep helpers shared by the TX packet loader
// Purpose: controller MMIO addresses, op_size / FSM state / error code enums, and
//          byte-enable helpers used by eth_tx_pkt_loader and eth_tx_tail_splitter.
// Ports:   none (package).
package eth_ctrl_pkg;

  localparam logic [15:0] TX_BUF_BASE = 16'h0800;
  localparam logic [15:0] TX_SEND     = 16'h1018;
  localparam logic [15:0] TX_READY    = 16'h101C;
  localparam logic [15:0] TX_SIZE     = 16'h1028;

  typedef enum logic [1:0] {
    OP_1B = 2'd0,
    OP_2B = 2'd1,
    OP_4B = 2'd2,
    OP_8B = 2'd3
  } op_size_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_POLL_REQ  = 3'd1,
    ST_POLL_WAIT = 3'd2,
    ST_STREAM    = 3'd3,
    ST_SIZE      = 3'd4,
    ST_SEND      = 3'd5,
    ST_DRAIN     = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE         = 2'd0,
    ERR_POLL_TIMEOUT = 2'd1,
    ERR_OVERSIZE     = 2'd2,
    ERR_BAD_KEEP     = 2'd3
  } err_code_e;

  function automatic logic [3:0] keep_count(input logic [7:0] keep);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, keep[i]};
    end
    return n;
  endfunction

  // A legal tail keep is a nonzero run of ones starting at bit 0 (2^n - 1).
  function automatic logic keep_contiguous(input logic [7:0] keep);
    return (keep != 8'h00) && ((keep & (keep + 8'h01)) == 8'h00);
  endfunction

endpackage

// File: rtl/eth_tx_tail_splitter.sv
// rtl/eth_tx_tail_splitter.sv - picks the next 4B/2B/1B MMIO piece of a partial tail beat
// Purpose: given the bytes still to write from a tail beat and how many were already
//          written, produce the next piece (largest first) LSB-aligned.
// Ports:   tail_rem    in  3   bytes of the tail not yet written (1..7)
//          tail_done   in  3   bytes of the tail already written (byte offset of this piece)
//          beat_data   in  64  the held tail beat
//          op_size     out 2   size code of this piece
//          piece_bytes out 3   byte count of this piece
//          offset      out 3   byte offset of this piece within the beat
//          piece_data  out 64  piece bytes shifted down to bit 0, upper bits zero
//          last_piece  out 1   this piece finishes the tail
module eth_tx_tail_splitter
  import eth_ctrl_pkg::*;
(
  input  logic [2:0]  tail_rem,
  input  logic [2:0]  tail_done,
  input  logic [63:0] beat_data,
  output op_size_e    op_size,
  output logic [2:0]  piece_bytes,
  output logic [2:0]  offset,
  output logic [63:0] piece_data,
  output logic        last_piece
);

  logic [63:0] shifted;

  always_comb begin
    op_size     = OP_1B;
    piece_bytes = 3'd1;
    if (tail_rem[2]) begin
      op_size     = OP_4B;
      piece_bytes = 3'd4;
    end else if (tail_rem[1]) begin
      op_size     = OP_2B;
      piece_bytes = 3'd2;
    end

    shifted = beat_data >> {tail_done, 3'b000};

    case (op_size)
      OP_4B:   piece_data = {32'd0, shifted[31:0]};
      OP_2B:   piece_data = {48'd0, shifted[15:0]};
      default: piece_data = {56'd0, shifted[7:0]};
    endcase

    last_piece = (tail_rem == piece_bytes);
  end

  assign offset = tail_done;

endmodule

// File: rtl/eth_tx_pkt_loader.sv
// rtl/eth_tx_pkt_loader.sv - streams one packet into the ethernet controller TX buffer over MMIO
// Purpose: per packet, poll TX-ready, write the buffer (8B beats, 4/2/1B tail pieces),
//          write the size, kick send; abort into a drain on poll timeout, oversize or bad keep.
// Optional: ETH_TX_LOADER_STATS_EN adds stats_clr_i, pkt_cnt_o, byte_cnt_o.
// Ports:   clk_i, reset_n_i                      clock, async active-low reset
//          s_data_i/s_keep_i/s_last_i/s_valid_i  packet stream in; s_ready_o accepts
//          addr_o/write_en_o/read_en_o/op_size_o/write_data_o  MMIO request to controller
//          read_data_i/read_data_v_i             MMIO read response (cycle after read_en_o)
//          busy_o, sent_o, err_o, err_code_o     status
module eth_tx_pkt_loader
  import eth_ctrl_pkg::*;
#(
  parameter int buf_size_p       = 2048,
  parameter int axis_width_p     = 64,
  parameter int reg_addr_width_p = 16,
  parameter int poll_limit_p     = 100000
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [axis_width_p-1:0]     s_data_i,
  input  logic [axis_width_p/8-1:0]   s_keep_i,
  input  logic                        s_last_i,
  input  logic                        s_valid_i,
  output logic                        s_ready_o,
  output logic [reg_addr_width_p-1:0] addr_o,
  output logic                        write_en_o,
  output logic                        read_en_o,
  output logic [1:0]                  op_size_o,
  output logic [axis_width_p-1:0]     write_data_o,
  input  logic [axis_width_p-1:0]     read_data_i,
  input  logic                        read_data_v_i,
  output logic                        busy_o,
  output logic                        sent_o,
  output logic                        err_o,
  output logic [1:0]                  err_code_o
`ifdef ETH_TX_LOADER_STATS_EN
  ,
  input  logic                        stats_clr_i,
  output logic [31:0]                 pkt_cnt_o,
  output logic [31:0]                 byte_cnt_o
`endif
);

  localparam int cnt_w = $clog2(buf_size_p + 1);

  state_e                state_q, state_d;
  logic [cnt_w-1:0]      byte_cnt_q, byte_cnt_d;
  logic [31:0]           poll_cnt_q, poll_cnt_d;
  logic                  tail_active_q, tail_active_d;
  logic [2:0]            tail_rem_q, tail_rem_d;
  logic [2:0]            tail_done_q, tail_done_d;
  logic                  err_q;
  err_code_e             err_code_q;
  err_code_e             abort_code;

  logic [3:0]            keep_n;
  logic                  keep_ok;
  logic [2:0]            rem_sel, done_sel;
  logic [cnt_w:0]        full_end, tail_end;
  logic [reg_addr_width_p-1:0] buf_addr;

  op_size_e              piece_op;
  logic [2:0]            piece_bytes, piece_off;
  logic [63:0]           piece_data;
  logic                  piece_last;

  logic                  unused_rd_hi;
  assign unused_rd_hi = ^read_data_i[axis_width_p-1:32];

  assign keep_n   = keep_count(s_keep_i);
  assign keep_ok  = keep_contiguous(s_keep_i);
  // The first tail piece is chosen straight from the keep; later pieces from the saved remainder.
  assign rem_sel  = tail_active_q ? tail_rem_q  : keep_n[2:0];
  assign done_sel = tail_active_q ? tail_done_q : 3'd0;
  assign full_end = {1'b0, byte_cnt_q} + (cnt_w+1)'(8);
  assign tail_end = {1'b0, byte_cnt_q} + (cnt_w+1)'(keep_n);
  // byte_cnt stays at the start of the beat until its last piece, so offset is the within-beat position.
  assign buf_addr = reg_addr_width_p'(TX_BUF_BASE) + reg_addr_width_p'(byte_cnt_q)
                  + reg_addr_width_p'(piece_off);

  eth_tx_tail_splitter u_tail_splitter (
    .tail_rem    (rem_sel),
    .tail_done   (done_sel),
    .beat_data   (s_data_i),
    .op_size     (piece_op),
    .piece_bytes (piece_bytes),
    .offset      (piece_off),
    .piece_data  (piece_data),
    .last_piece  (piece_last)
  );

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    poll_cnt_d    = poll_cnt_q;
    tail_active_d = tail_active_q;
    tail_rem_d    = tail_rem_q;
    tail_done_d   = tail_done_q;
    abort_code    = ERR_NONE;
    s_ready_o     = 1'b0;
    addr_o        = '0;
    write_en_o    = 1'b0;
    read_en_o     = 1'b0;
    op_size_o     = OP_1B;
    write_data_o  = '0;
    sent_o        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        byte_cnt_d    = '0;
        poll_cnt_d    = '0;
        tail_active_d = 1'b0;
        tail_rem_d    = '0;
        tail_done_d   = '0;
        if (s_valid_i) state_d = ST_POLL_REQ;
      end

      ST_POLL_REQ: begin
        read_en_o = 1'b1;
        addr_o    = reg_addr_width_p'(TX_READY);
        op_size_o = OP_4B;
        state_d   = ST_POLL_WAIT;
      end

      ST_POLL_WAIT: begin
        if (read_data_v_i) begin
          if (read_data_i[31:0] == 32'd1) begin
            state_d = ST_STREAM;
          end else begin
            // Compared before the increment: poll_limit_p retries follow the first read.
            poll_cnt_d = poll_cnt_q + 32'd1;
            if (poll_cnt_q == 32'(poll_limit_p)) begin
              abort_code = ERR_POLL_TIMEOUT;
              state_d    = ST_DRAIN;
            end else begin
              state_d = ST_POLL_REQ;
            end
          end
        end
      end

      ST_STREAM: begin
        if (s_valid_i) begin
          if (!tail_active_q && s_keep_i == '1) begin
            if (full_end > (cnt_w+1)'(buf_size_p)) begin
              abort_code = ERR_OVERSIZE;
              state_d    = ST_DRAIN;
            end else begin
              write_en_o   = 1'b1;
              addr_o       = buf_addr;
              op_size_o    = OP_8B;
              write_data_o = s_data_i;
              s_ready_o    = 1'b1;
              byte_cnt_d   = full_end[cnt_w-1:0];
              if (s_last_i) state_d = ST_SIZE;
            end
          end else if (!tail_active_q && (!s_last_i || !keep_ok)) begin
            abort_code = ERR_BAD_KEEP;
            state_d    = ST_DRAIN;
          end else if (!tail_active_q && tail_end > (cnt_w+1)'(buf_size_p)) begin
            abort_code = ERR_OVERSIZE;
            state_d    = ST_DRAIN;
          end else begin
            // Tail beat is held (ready low) until its final piece is written.
            write_en_o   = 1'b1;
            addr_o       = buf_addr;
            op_size_o    = piece_op;
            write_data_o = piece_data;
            if (piece_last) begin
              s_ready_o     = 1'b1;
              byte_cnt_d    = tail_end[cnt_w-1:0];
              tail_active_d = 1'b0;
              state_d       = ST_SIZE;
            end else begin
              tail_active_d = 1'b1;
              tail_rem_d    = rem_sel - piece_bytes;
              tail_done_d   = done_sel + piece_bytes;
            end
          end
        end
      end

      ST_SIZE: begin
        write_en_o   = 1'b1;
        addr_o       = reg_addr_width_p'(TX_SIZE);
        op_size_o    = OP_4B;
        write_data_o = axis_width_p'(byte_cnt_q);
        state_d      = ST_SEND;
      end

      ST_SEND: begin
        write_en_o = 1'b1;
        addr_o     = reg_addr_width_p'(TX_SEND);
        op_size_o  = OP_4B;
        sent_o     = 1'b1;
        byte_cnt_d = '0;
        state_d    = ST_IDLE;
      end

      ST_DRAIN: begin
        s_ready_o = 1'b1;
        if (s_valid_i && s_last_i) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= ST_IDLE;
      byte_cnt_q    <= '0;
      poll_cnt_q    <= '0;
      tail_active_q <= 1'b0;
      tail_rem_q    <= '0;
      tail_done_q   <= '0;
      err_q         <= 1'b0;
      err_code_q    <= ERR_NONE;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      poll_cnt_q    <= poll_cnt_d;
      tail_active_q <= tail_active_d;
      tail_rem_q    <= tail_rem_d;
      tail_done_q   <= tail_done_d;
      // err_o lands on the first DRAIN cycle together with the new code.
      err_q         <= (abort_code != ERR_NONE);
      if (abort_code != ERR_NONE) err_code_q <= abort_code;
    end
  end

  assign busy_o     = (state_q != ST_IDLE);
  assign err_o      = err_q;
  assign err_code_o = err_code_q;

`ifdef ETH_TX_LOADER_STATS_EN
  logic [31:0] pkt_cnt_q, stat_bytes_q;
  logic [31:0] pkt_len;
  logic        pkt_sent;

  assign pkt_sent = (state_q == ST_SEND);
  assign pkt_len  = 32'(byte_cnt_q);

  // A clear coincident with a send still counts that send.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pkt_cnt_q    <= '0;
      stat_bytes_q <= '0;
    end else if (stats_clr_i) begin
      pkt_cnt_q    <= pkt_sent ? 32'd1   : 32'd0;
      stat_bytes_q <= pkt_sent ? pkt_len : 32'd0;
    end else if (pkt_sent) begin
      pkt_cnt_q    <= pkt_cnt_q + 32'd1;
      stat_bytes_q <= stat_bytes_q + pkt_len;
    end
  end

  assign pkt_cnt_o  = pkt_cnt_q;
  assign byte_cnt_o = stat_bytes_q;
`endif

  poll_data_arrives: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (state_q == ST_POLL_WAIT) |-> read_data_v_i);

endmodule
